spi_imu_responder: RTL and testbench
====================================

// Module: spi_imu_responder
// PURPOSE
//  SPI slave model of a gyro/accel IMU. It answers the attitude_estimation SPI master: one instance per chip select (SS_G / SS_A).
//  Serves a 64x8 register file: WHO_AM_I, CTRL, STATUS and six output-data bytes loaded from a sample port.
//  Used in simulation benches, and as an FPGA loopback sensor for bring-up.
// PARAMETERS
//  WHO_AM_I_VAL  8'hD4  read-only value at address 0x0F
//  CTRL_BASE     6'h20  first writable control register
//  NUM_CTRL      5      writable registers CTRL_BASE..CTRL_BASE+NUM_CTRL-1
//  STATUS_ADDR   6'h27  status register: bit3 ZYXDA, bit7 ZYXOR
//  DATA_BASE     6'h28  OUT_X_L; six data bytes at 0x28..0x2D
// PORTS
//  clk           in   1   system clock, oversamples SCLK
//  reset         in   1   asynchronous, active-low reset
//  SCLK          in   1   SPI clock, mode 3 (CPOL=1, CPHA=1)
//  SS            in   1   chip select, active-low
//  MOSI          in   1   serial data in, MSB first
//  MISO          out  1   serial data out, MSB first
//  sample_valid  in   1   one-cycle strobe: new sample on sample_data
//  sample_data   in   48  [7:0]->0x28, [15:8]->0x29, ..., [47:40]->0x2D
//  ctrl_reg1     out  8   live copy of register CTRL_BASE
//  frame_done    out  1   one-cycle pulse on SS deassertion
// BEHAVIOUR
//  - Reset values: MISO=0, ctrl_reg1=0, frame_done=0, all registers 0 (except WHO_AM_I), state IDLE, armed=0.
//  - SCLK, SS and MOSI pass through 2-FF synchronizers. Edges are taken from the synchronized values.
//    Synchronizer reset value is 1 for SCLK and SS.
//  - Timing requirement: each SCLK high/low phase lasts at least 4 clk cycles.
//  - armed is set when synchronized SS is high. A frame starts only on an SS falling edge while armed,
//    so a frame already in progress at reset release is ignored.
//  - FSM states: IDLE -> CMD (SS fall) -> DATA (8th rising edge in CMD). SS rise from any state -> IDLE.
//  - Command byte (8th rising edge): bit7 RW (1=read), bit6 MS (auto-increment), bits[5:0] addr.
//  - SCLK rising edge, SS low: rx_shift <= {rx_shift[6:0],MOSI}; bit_cnt++ (3-bit, wraps).
//  - Read path:
//    - On the command byte's 8th edge, load tx_shift <= reg[addr].
//    - In DATA, each SCLK falling edge: MISO <= tx_shift[7]; tx_shift <<= 1.
//    - At each byte end, when MS=1: addr++ and reload tx_shift.
//  - Write path: at each data byte end, reg[addr] <= rx_shift, only if addr is in the CTRL range.
//    Then addr++ when MS=1.
//  - Address auto-increment wraps 0x3F->0x00. With MS=0, addr is held and the same register repeats.
//  - Unmapped addresses read 0x00. Writes outside the CTRL range are ignored.
//  - MISO is 0 in IDLE and CMD, and in DATA during write commands.
//  - SS rise (sync): frame_done=1 for one cycle, MISO=0, bit_cnt=0. A partial byte is discarded: no write, no addr change.
//  - Sample update:
//    - sample_valid in IDLE: data registers load on the next cycle; ZYXDA=1.
//    - sample_valid in CMD/DATA: held in a one-deep pending buffer.
//    - The pending sample is applied in the cycle frame_done pulses. Register content never changes mid-frame.
//    - A sample_valid while a sample is pending overwrites it and sets ZYXOR.
//    - A sample_valid while ZYXDA=1 also sets ZYXOR.
//    - Simultaneous SS rise and sample_valid: the new sample is applied; no overrun from that event alone.
//  - Status clear: completing the 8th rising edge of a read byte at 0x2D clears ZYXDA and ZYXOR.
//    If a pending sample is applied at the same frame end, ZYXDA=1 again.
// STRUCTURE
//  - spi_imu_defs.vh: address constants (WHO_AM_I, CTRL1, STATUS, OUT_X_L..OUT_Z_H), state encodings, status bit indices.
//  - Sub-module spi_edge_sync: 2-FF synchronizer with rise/fall pulse outputs and a reset value parameter. Instantiated for SCLK and SS.
//  - Register file, FSM and shifters stay in this module.
// TESTING
//  1. Release reset; frame 0x8F + 8 dummy clocks -> MISO byte 0xD4; frame_done pulses once.
//  2. sample_valid, sample_data=48'h010203040506; burst read 0xE8 + 6 bytes -> 06 05 04 03 02 01.
//     Read 0x27 -> 0x00 (ZYXDA cleared).
//  3. Write 0x20 data 0x0F -> ctrl_reg1=0x0F.
//     Write 0x0F data 0x55 -> read 0x8F still returns 0xD4.
//  4. Start a read of 0x28; sample_valid A then B mid-frame -> in-frame byte is the old value.
//     After SS high, 0x28 holds B's byte; 0x27 reads 0x88.
//  5. Write 0x20=0x11, 0x21=0x22. Burst read 0xFF (read, MS, addr 0x3F) + 2 bytes -> 0x00 (0x3F), then 0x00 (wrapped to 0x00).
//     Read 0xE0 + 2 bytes -> 0x11, 0x22.
//  6. Write 0x20, SS high after 5 data bits -> ctrl_reg1 unchanged.
//     Assert reset mid-read with SS low -> MISO=0, no response until SS high then low; next read of 0x8F -> 0xD4.

Source files
------------

// File: rtl/spi_imu_responder_pkg.sv
// Shared definitions for the SPI IMU responder: register map, FSM state
// encoding and status-register bit positions.
package spi_imu_responder_pkg;

    // Register map of the emulated gyro/accel part
    localparam logic [7:0] WHO_AM_I_DEFAULT = 8'hD4;
    localparam logic [5:0] ADDR_WHO_AM_I    = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1       = 6'h20;
    localparam logic [5:0] ADDR_STATUS      = 6'h27;
    localparam logic [5:0] ADDR_OUT_X_L     = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H     = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L     = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H     = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L     = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H     = 6'h2D;

    localparam int NUM_CTRL_DEFAULT = 5;
    localparam int NUM_DATA_BYTES   = 6;

    // Status register bits
    localparam int STATUS_ZYXDA_BIT = 3;
    localparam int STATUS_ZYXOR_BIT = 7;

    // Frame sequencing: waiting for SS, shifting the command byte, data bytes
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_imu_responder_if.sv
// SPI bus between the attitude-estimation master and one IMU responder.
//   SCLK  serial clock, mode 3 (idles high)
//   SS    chip select, active-low
//   MOSI  master-to-responder data, MSB first
//   MISO  responder-to-master data, MSB first
interface spi_imu_responder_if;
    logic SCLK;
    logic SS;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output SS, output MOSI, input MISO);
    modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_imu_responder_edge_sync.sv
// spi_edge_sync: two-flop synchronizer for an asynchronous input with
// single-cycle rise/fall pulses derived from the synchronized level.
//   clk    system clock
//   reset  asynchronous, active-low
//   d      asynchronous input
//   level  synchronized level
//   rise   one-cycle pulse on a synchronized 0->1 transition
//   fall   one-cycle pulse on a synchronized 1->0 transition
module spi_edge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // The third flop only remembers the previous synchronized value for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= RESET_VAL;
            sync   <= RESET_VAL;
            sync_d <= RESET_VAL;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_d;
    assign fall  = ~sync & sync_d;

endmodule

// File: rtl/spi_imu_responder.sv
// spi_imu_responder: SPI mode-3 slave emulating a gyro/accel IMU register file.
//   clk           system clock, oversamples SCLK (each SCLK phase >= 4 clk)
//   reset         asynchronous, active-low
//   spi           SPI bus (slave modport): SCLK, SS, MOSI in, MISO out
//   sample_valid  one-cycle strobe: new sample on sample_data
//   sample_data   six output bytes, [7:0] -> DATA_BASE ... [47:40] -> DATA_BASE+5
//   ctrl_reg1     live copy of register CTRL_BASE
//   frame_done    one-cycle pulse when SS deasserts
// Command byte: bit7 read, bit6 auto-increment, bits[5:0] address.
module spi_imu_responder
    import spi_imu_responder_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = WHO_AM_I_DEFAULT,
    parameter logic [5:0] CTRL_BASE    = ADDR_CTRL1,
    parameter int         NUM_CTRL     = NUM_CTRL_DEFAULT,
    parameter logic [5:0] STATUS_ADDR  = ADDR_STATUS,
    parameter logic [5:0] DATA_BASE    = ADDR_OUT_X_L
) (
    input  logic                clk,
    input  logic                reset,
    spi_imu_responder_if.slave  spi,
    input  logic                sample_valid,
    input  logic [47:0]         sample_data,
    output logic [7:0]          ctrl_reg1,
    output logic                frame_done
);

    logic        sclk_level_unused;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        ss_level;
    logic        ss_rise;
    logic        ss_fall;
    logic        mosi_meta;
    logic        mosi_sync;
    logic [1:0]  primed;
    logic        armed;
    spi_state_t  state;
    spi_state_t  state_next;
    logic        frame_start;
    logic        byte_end;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_next;
    logic [2:0]  bit_cnt;
    logic        cmd_rw;
    logic        cmd_ms;
    logic [5:0]  addr;
    logic [5:0]  addr_next;
    logic [7:0]  tx_shift;
    logic        miso_q;
    logic [7:0]  ctrl_regs [NUM_CTRL];
    logic [47:0] out_data;
    logic [47:0] pend_data;
    logic        pending;
    logic        zyxda;
    logic        zyxor;
    logic [7:0]  status_byte;
    logic        status_clear;

    spi_edge_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi.SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_sync #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi.SS),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // MOSI gets the same two-flop delay as SCLK so data and clock edges stay aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= spi.MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    // The SS synchronizer resets to 1, which is not a real observation of SS.
    // primed waits until the pipeline holds genuine samples before SS-high may arm,
    // so a frame already running at reset release is ignored until SS goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed <= 2'b00;
            armed  <= 1'b0;
        end else begin
            primed <= {primed[0], 1'b1};
            if (primed[1] && ss_level) begin
                armed <= 1'b1;
            end
        end
    end

    // Register read mux; anything unmapped reads zero
    function automatic logic [7:0] read_reg(input logic [5:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a == ADDR_WHO_AM_I) v = WHO_AM_I_VAL;
        if (a == STATUS_ADDR) v = status_byte;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (a == CTRL_BASE + 6'(i)) v = ctrl_regs[i];
        end
        for (int i = 0; i < NUM_DATA_BYTES; i++) begin
            if (a == DATA_BASE + 6'(i)) v = out_data[8*i +: 8];
        end
        return v;
    endfunction

    // Frame-level decode shared by the FSM, shifters and status logic
    always_comb begin
        rx_next      = {rx_shift, mosi_sync};
        addr_next    = cmd_ms ? addr + 6'd1 : addr;
        frame_start  = ss_fall && armed && (state == ST_IDLE);
        byte_end     = sclk_rise && !ss_rise && (state != ST_IDLE) && (bit_cnt == 3'd7);
        status_clear = byte_end && (state == ST_DATA) && cmd_rw &&
                       (addr == DATA_BASE + 6'(NUM_DATA_BYTES - 1));
        status_byte  = 8'h00;
        status_byte[STATUS_ZYXDA_BIT] = zyxda;
        status_byte[STATUS_ZYXOR_BIT] = zyxor;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // SS deassertion aborts from any state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (frame_start) state_next = ST_CMD;
            ST_CMD:  if (byte_end) state_next = ST_DATA;
            ST_DATA: state_next = ST_DATA;
            default: state_next = ST_IDLE;
        endcase
        if (ss_rise) begin
            state_next = ST_IDLE;
        end
    end

    // Shifters, address pointer and control registers. Bytes complete on the
    // 8th rising edge; a byte cut short by SS rising is simply dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_shift   <= '0;
            bit_cnt    <= '0;
            cmd_rw     <= 1'b0;
            cmd_ms     <= 1'b0;
            addr       <= '0;
            tx_shift   <= '0;
            miso_q     <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_regs[i] <= '0;
            end
        end else begin
            frame_done <= ss_rise;
            if (ss_rise) begin
                miso_q  <= 1'b0;
                bit_cnt <= '0;
            end else if (frame_start) begin
                miso_q   <= 1'b0;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (state != ST_IDLE) begin
                if (sclk_rise) begin
                    rx_shift <= rx_next[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == ST_CMD) begin
                            cmd_rw   <= rx_next[7];
                            cmd_ms   <= rx_next[6];
                            addr     <= rx_next[5:0];
                            tx_shift <= read_reg(rx_next[5:0]);
                        end else begin
                            for (int i = 0; i < NUM_CTRL; i++) begin
                                if (!cmd_rw && (addr == CTRL_BASE + 6'(i))) begin
                                    ctrl_regs[i] <= rx_next;
                                end
                            end
                            // Reloading even without auto-increment repeats the same register
                            addr     <= addr_next;
                            tx_shift <= read_reg(addr_next);
                        end
                    end
                end
                if (sclk_fall && (state == ST_DATA) && cmd_rw) begin
                    miso_q   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    // Sample capture. Data registers only change outside a frame; a sample
    // arriving mid-frame waits in a one-deep buffer until SS rises.
    // Set conditions come after the clear so a coincident new event wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            pend_data <= '0;
            pending   <= 1'b0;
            zyxda     <= 1'b0;
            zyxor     <= 1'b0;
        end else begin
            if (status_clear) begin
                zyxda <= 1'b0;
                zyxor <= 1'b0;
            end
            if (ss_rise) begin
                if (sample_valid) begin
                    out_data <= sample_data;
                    zyxda    <= 1'b1;
                    pending  <= 1'b0;
                    if (zyxda) zyxor <= 1'b1;
                end else if (pending) begin
                    out_data <= pend_data;
                    zyxda    <= 1'b1;
                    pending  <= 1'b0;
                end
            end else if (sample_valid) begin
                if (zyxda) zyxor <= 1'b1;
                if (state == ST_IDLE) begin
                    out_data <= sample_data;
                    zyxda    <= 1'b1;
                end else begin
                    if (pending) zyxor <= 1'b1;
                    pend_data <= sample_data;
                    pending   <= 1'b1;
                end
            end
        end
    end

    assign spi.MISO  = miso_q;
    assign ctrl_reg1 = ctrl_regs[0];

endmodule

// File: tb/tb_spi_imu_responder.sv
// Testbench for spi_imu_responder: directed scenarios followed by random
// frames, all checked against a transaction-level register model.
module tb_spi_imu_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [47:0] sample_data;
    logic [7:0]  ctrl_reg1;
    logic        frame_done;

    spi_imu_responder_if bus ();

    spi_imu_responder dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (bus),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ctrl_reg1    (ctrl_reg1),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    // Count clock cycles with frame_done high
    always @(negedge clk) begin
        if (frame_done) fd_count++;
    end

    // Reference model of the register file
    logic [7:0]  m_ctrl [5];
    logic [7:0]  m_data [6];
    logic        m_zyxda;
    logic        m_zyxor;
    logic        m_pending;
    logic [47:0] m_pend;

    // Frame buffers
    logic [7:0]  tx_bytes [8];
    logic [7:0]  rx_bytes [8];
    logic [7:0]  exp_bytes [8];
    logic [47:0] mid_samples [4];
    int          n_mid;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_read(input int a);
        if (a == 'h0F) return 8'hD4;
        if (a >= 'h20 && a <= 'h24) return m_ctrl[a - 'h20];
        if (a == 'h27) return {m_zyxor, 3'b000, m_zyxda, 3'b000};
        if (a >= 'h28 && a <= 'h2D) return m_data[a - 'h28];
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) m_ctrl[k] = 8'h00;
        for (int k = 0; k < 6; k++) m_data[k] = 8'h00;
        m_zyxda   = 1'b0;
        m_zyxor   = 1'b0;
        m_pending = 1'b0;
        m_pend    = '0;
    endtask

    task automatic model_load(input logic [47:0] d);
        for (int k = 0; k < 6; k++) m_data[k] = d[8*k +: 8];
        m_zyxda = 1'b1;
    endtask

    task automatic model_sample_idle(input logic [47:0] d);
        if (m_zyxda) m_zyxor = 1'b1;
        model_load(d);
    endtask

    task automatic model_sample_frame(input logic [47:0] d);
        if (m_zyxda || m_pending) m_zyxor = 1'b1;
        m_pending = 1'b1;
        m_pend    = d;
    endtask

    // Whole-frame effect: mid-frame samples, complete bytes in order, then frame end
    task automatic model_frame(input int n_bits);
        int  n_full;
        int  a;
        logic rw;
        logic ms;
        logic [7:0] cmd;
        for (int m = 0; m < n_mid; m++) model_sample_frame(mid_samples[m]);
        for (int k = 0; k < 8; k++) exp_bytes[k] = 8'h00;
        n_full = n_bits / 8;
        if (n_full > 0) begin
            cmd = tx_bytes[0];
            rw  = cmd[7];
            ms  = cmd[6];
            a   = int'(cmd[5:0]);
            for (int k = 1; k < n_full; k++) begin
                if (rw) begin
                    exp_bytes[k] = model_read(a);
                    if (a == 'h2D) begin
                        m_zyxda = 1'b0;
                        m_zyxor = 1'b0;
                    end
                end else if (a >= 'h20 && a <= 'h24) begin
                    m_ctrl[a - 'h20] = tx_bytes[k];
                end
                if (ms) a = (a + 1) % 64;
            end
        end
        if (m_pending) begin
            model_load(m_pend);
            m_pending = 1'b0;
        end
    endtask

    task automatic pulse_sample(input logic [47:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        wait_clks(1);
        sample_valid = 1'b0;
        wait_clks(1);
    endtask

    // Mode 3: drive MOSI after the falling edge, capture MISO just before the rising edge
    task automatic clock_bits(input int n_bits);
        logic [7:0] cur;
        for (int b = 0; b < n_bits; b++) begin
            cur = tx_bytes[b / 8];
            bus.SCLK = 1'b0;
            bus.MOSI = cur[7 - (b % 8)];
            wait_clks(8);
            cur = rx_bytes[b / 8];
            cur[7 - (b % 8)] = bus.MISO;
            rx_bytes[b / 8] = cur;
            bus.SCLK = 1'b1;
            wait_clks(8);
        end
    endtask

    task automatic spi_xfer(input int n_bits);
        for (int k = 0; k < 8; k++) rx_bytes[k] = 8'h00;
        bus.SS = 1'b0;
        wait_clks(8);
        for (int m = 0; m < n_mid; m++) begin
            pulse_sample(mid_samples[m]);
        end
        clock_bits(n_bits);
        bus.SS = 1'b0;
        wait_clks(2);
        bus.SS = 1'b1;
        wait_clks(12);
        n_mid = 0;
    endtask

    task automatic apply_stimulus(input string tag, input int n_bits);
        model_frame(n_bits);
        spi_xfer(n_bits);
        for (int k = 0; k < n_bits / 8; k++) begin
            check_output($sformatf("%s_byte%0d", tag, k), rx_bytes[k], exp_bytes[k]);
        end
        check_output({tag, "_ctrl_reg1"}, ctrl_reg1, m_ctrl[0]);
    endtask

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        for (int k = 0; k < 8; k++) tx_bytes[k] = 8'h00;
        tx_bytes[0] = b0;
        tx_bytes[1] = b1;
        tx_bytes[2] = b2;
    endtask

    // Stop a hung run with a reported failure
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int          fd0;
        int          kind;
        int          len;
        int          cut;
        logic [63:0] r;
        logic        ms;
        logic [5:0]  a;

        reset        = 1'b0;
        bus.SCLK     = 1'b1;
        bus.SS       = 1'b1;
        bus.MOSI     = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        n_mid        = 0;
        model_reset();

        wait_clks(4);
        check_output("reset_miso", bus.MISO, 1'b0);
        check_output("reset_ctrl_reg1", ctrl_reg1, 8'h00);
        check_output("reset_frame_done", frame_done, 1'b0);
        reset = 1'b1;
        wait_clks(6);

        // WHO_AM_I read and a single frame_done pulse
        fd0 = fd_count;
        set_tx(8'h8F, 8'h00, 8'h00);
        apply_stimulus("who_am_i", 16);
        check_output("who_am_i_value", rx_bytes[1], 8'hD4);
        check_output("frame_done_cycles", fd_count - fd0, 1);

        // Sample load in idle, burst read of all six bytes, status clear
        pulse_sample(48'h010203040506);
        model_sample_idle(48'h010203040506);
        set_tx(8'hE8, 8'h00, 8'h00);
        apply_stimulus("burst", 56);
        check_output("burst_first", rx_bytes[1], 8'h06);
        check_output("burst_last", rx_bytes[6], 8'h01);
        set_tx(8'hA7, 8'h00, 8'h00);
        apply_stimulus("status_cleared", 16);
        check_output("status_cleared_value", rx_bytes[1], 8'h00);

        // Control write and read-only WHO_AM_I
        set_tx(8'h20, 8'h0F, 8'h00);
        apply_stimulus("wr_ctrl1", 16);
        check_output("wr_ctrl1_value", ctrl_reg1, 8'h0F);
        set_tx(8'h0F, 8'h55, 8'h00);
        apply_stimulus("wr_who_am_i", 16);
        set_tx(8'h8F, 8'h00, 8'h00);
        apply_stimulus("who_am_i_ro", 16);
        check_output("who_am_i_ro_value", rx_bytes[1], 8'hD4);

        // Two samples mid-frame: old data in frame, newest applied after, overrun flagged
        mid_samples[0] = 48'h0A0B0C0D0E1F;
        mid_samples[1] = 48'h111213141516;
        n_mid = 2;
        set_tx(8'hA8, 8'h00, 8'h00);
        apply_stimulus("mid_frame", 16);
        check_output("mid_frame_old", rx_bytes[1], 8'h06);
        set_tx(8'hA8, 8'h00, 8'h00);
        apply_stimulus("after_frame", 16);
        check_output("after_frame_new", rx_bytes[1], 8'h16);
        set_tx(8'hA7, 8'h00, 8'h00);
        apply_stimulus("overrun", 16);
        check_output("overrun_status", rx_bytes[1], 8'h88);

        // Address wrap 0x3F -> 0x00 and control burst
        set_tx(8'h20, 8'h11, 8'h00);
        apply_stimulus("wr_0x20", 16);
        set_tx(8'h21, 8'h22, 8'h00);
        apply_stimulus("wr_0x21", 16);
        set_tx(8'hFF, 8'h00, 8'h00);
        apply_stimulus("wrap", 24);
        check_output("wrap_0x3f", rx_bytes[1], 8'h00);
        check_output("wrap_0x00", rx_bytes[2], 8'h00);
        set_tx(8'hE0, 8'h00, 8'h00);
        apply_stimulus("ctrl_burst", 24);
        check_output("ctrl_burst_0x20", rx_bytes[1], 8'h11);
        check_output("ctrl_burst_0x21", rx_bytes[2], 8'h22);

        // Partial data byte is discarded
        set_tx(8'h20, 8'hAA, 8'h00);
        apply_stimulus("partial", 13);
        check_output("partial_ctrl_reg1", ctrl_reg1, 8'h11);

        // Reset in the middle of a read with SS held low
        set_tx(8'h8F, 8'h00, 8'h00);
        bus.SS = 1'b0;
        wait_clks(8);
        clock_bits(4);
        reset = 1'b0;
        wait_clks(3);
        check_output("midreset_miso", bus.MISO, 1'b0);
        check_output("midreset_ctrl_reg1", ctrl_reg1, 8'h00);
        reset = 1'b1;
        wait_clks(4);
        for (int k = 0; k < 8; k++) rx_bytes[k] = 8'hFF;
        clock_bits(16);
        check_output("ignored_frame_cmd", rx_bytes[0], 8'h00);
        check_output("ignored_frame_data", rx_bytes[1], 8'h00);
        bus.SS = 1'b1;
        wait_clks(12);
        model_reset();
        set_tx(8'h8F, 8'h00, 8'h00);
        apply_stimulus("post_reset", 16);
        check_output("post_reset_value", rx_bytes[1], 8'hD4);

        // Random frames and samples
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                r = {$urandom, $urandom};
                pulse_sample(r[47:0]);
                model_sample_idle(r[47:0]);
            end else if (kind == 1) begin
                a   = ($urandom_range(0, 1) == 1) ? 6'(32 + $urandom_range(0, 13)) : 6'($urandom_range(0, 63));
                ms  = 1'($urandom_range(0, 1));
                len = int'($urandom_range(1, 3));
                set_tx({1'b1, ms, a}, 8'h00, 8'h00);
                n_mid = int'($urandom_range(0, 2));
                for (int m = 0; m < n_mid; m++) begin
                    r = {$urandom, $urandom};
                    mid_samples[m] = r[47:0];
                end
                apply_stimulus($sformatf("rand_rd%0d", t), 8 * (len + 1));
            end else if (kind == 2) begin
                a   = 6'($urandom_range(30, 38));
                ms  = 1'($urandom_range(0, 1));
                len = int'($urandom_range(1, 2));
                set_tx({1'b0, ms, a}, 8'($urandom), 8'($urandom));
                cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
                apply_stimulus($sformatf("rand_wr%0d", t), 8 * (len + 1) - cut);
            end else begin
                set_tx(8'hE7, 8'h00, 8'h00);
                apply_stimulus($sformatf("rand_st%0d", t), 64);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
